// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed hex driver for common-anode seven-segment
// banks. It scans DIGITS nibbles of a shadow register. Loads land in a pending
// buffer and move into the shadow only on a frame boundary, or at once while
// stopped, so the display never shows a half-updated value.
// Optional feature macro: SEG_SCAN_LZB_EN enables leading-zero blanking.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | run flag clear; display dark; pending commits on the next cycle
// ST_ARMED  | running, first tick not yet reached; display still dark
// ST_SCAN   | running, one digit lit, index advances on every tick
module seg_scan_display #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 20000,
  parameter int CNT_W    = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic [DIGITS-1:0]     led_en,
  output logic [6:0]            led_seg,
  output logic                  led_dp,
  output logic                  frame_done,
  output logic                  pend_valid
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SCAN  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*DIGITS-1:0]   shadow_val_q, shadow_val_d;
  logic [DIGITS-1:0]     shadow_dp_q, shadow_dp_d;
  logic [4*DIGITS-1:0]   pend_val_q, pend_val_d;
  logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [DIGITS-1:0]     led_en_q, led_en_d;
  logic [6:0]            led_seg_q, led_seg_d;
  logic                  led_dp_q, led_dp_d;
  logic                  frame_done_q, frame_done_d;

  logic                  tick;
  logic                  wrap;
  logic                  show;
  logic                  commit;
  logic [IDX_W-1:0]      idx_new;
  logic [4*DIGITS-1:0]   src_val;
  logic [DIGITS-1:0]     src_dp;
  logic [3:0]            nib;
  logic                  dp_bit;
  logic                  blank;
`ifdef SEG_SCAN_LZB_EN
  logic [IDX_W-1:0]      msnz;
`endif

  // Active-low {g,f,e,d,c,b,a} patterns for the sixteen hex glyphs.
  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h18;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h27;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Run control, divider, digit index, buffers and registered outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    led_en_d     = led_en_q;
    led_seg_d    = led_seg_q;
    led_dp_d     = led_dp_q;
    frame_done_d = 1'b0;
    wrap         = 1'b0;
    show         = 1'b0;
    idx_new      = idx_q;
    nib          = 4'h0;
    dp_bit       = 1'b0;
    blank        = 1'b0;

    tick   = (state_q != ST_IDLE) && (cnt_q == CNT_LAST);
    // A pending value commits on the first stopped cycle, whatever stop/start do.
    commit = (state_q == ST_IDLE) && pend_valid_q;

    if (stop) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      idx_d     = '0;
      led_en_d  = '1;
      led_seg_d = 7'h7F;
      led_dp_d  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
          if (tick) begin
            state_d = ST_SCAN;
            idx_new = '0;
            show    = 1'b1;
          end
        end
        ST_SCAN: begin
          cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
          if (tick) begin
            wrap         = (idx_q == IDX_LAST);
            idx_new      = wrap ? '0 : idx_q + IDX_W'(1);
            show         = 1'b1;
            frame_done_d = wrap;
            commit       = wrap && pend_valid_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Digit 0 of a new frame already shows the committed data.
    src_val = commit ? pend_val_q : shadow_val_q;
    src_dp  = commit ? pend_dp_q  : shadow_dp_q;

    for (int i = 0; i < DIGITS; i++) begin
      if (idx_new == IDX_W'(i)) begin
        nib    = src_val[4*i +: 4];
        dp_bit = src_dp[i];
      end
    end

`ifdef SEG_SCAN_LZB_EN
    msnz = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (src_val[4*i +: 4] != 4'h0) msnz = IDX_W'(i);
    end
    blank = (idx_new > msnz);
`endif

    if (show) begin
      idx_d = idx_new;
      for (int i = 0; i < DIGITS; i++) begin
        led_en_d[i] = (idx_new != IDX_W'(i));
      end
      led_seg_d = blank ? 7'h7F : decode(nib);
      led_dp_d  = ~dp_bit;
    end

    if (commit) begin
      shadow_val_d = pend_val_q;
      shadow_dp_d  = pend_dp_q;
      pend_valid_d = 1'b0;
    end
    // A load in the commit cycle lands after the old pending moved out.
    if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp_mask;
      pend_valid_d = 1'b1;
    end
  end

  // State register with asynchronous clear to the dark, empty condition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      led_en_q     <= '1;
      led_seg_q    <= 7'h7F;
      led_dp_q     <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      led_en_q     <= led_en_d;
      led_seg_q    <= led_seg_d;
      led_dp_q     <= led_dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign led_en     = led_en_q;
  assign led_seg    = led_seg_q;
  assign led_dp     = led_dp_q;
  assign frame_done = frame_done_q;
  assign pend_valid = pend_valid_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display with DIGITS=4, SCAN_DIV=4. The reference model
// derives the lit digit from elapsed cycles since start and applies pending
// data at frame boundaries. Builds with or without SEG_SCAN_LZB_EN.
module tb_seg_scan_display;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int CNT_W    = 4;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic [3:0]  led_en;
  logic [6:0]  led_seg;
  logic        led_dp;
  logic        frame_done;
  logic        pend_valid;

  int errors = 0;
  int checks = 0;
  int e = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};

  seg_scan_display #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .load(load),
    .value(value), .dp_mask(dp_mask), .led_en(led_en), .led_seg(led_seg),
    .led_dp(led_dp), .frame_done(frame_done), .pend_valid(pend_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d);
    logic [3:0] n;
    int hi;
    n  = v[4*d +: 4];
    hi = 0;
    for (int i = 0; i < DIGITS; i++) if (v[4*i +: 4] != 4'h0) hi = i;
`ifdef SEG_SCAN_LZB_EN
    if (d > hi) return 7'h7F;
`endif
    return seg_tab[n];
  endfunction

  function automatic logic [3:0] exp_en(input int d);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << d);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    load  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; stop = 0; load = 0; value = '0; dp_mask = '0;
    #2;
    checks++;
    if ({led_en, led_seg, led_dp, frame_done, pend_valid} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_async: got en=%h seg=%h dp=%b fd=%b pv=%b", led_en, led_seg, led_dp, frame_done, pend_valid);
    end
    repeat (3) cyc();
    rst = 1'b0;
    for (int k = 0; k < 50; k++) begin
      cyc();
      checks++;
      if ({led_en, led_seg, led_dp, frame_done, pend_valid} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL idle_dark cyc %0d: got en=%h seg=%h dp=%b fd=%b pv=%b want F 7f 1 0 0", k, led_en, led_seg, led_dp, frame_done, pend_valid);
      end
    end
  endtask

  task automatic test_directed();
    logic [3:0] en_w [5] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
    logic [6:0] sg_w [5] = '{7'h0E, 7'h08, 7'h24, 7'h79, 7'h0E};
    logic       dp_w [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       fd_w [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    value = 16'h12AF; dp_mask = 4'b0010; load = 1'b1;
    cyc();
    checks++;
    if (pend_valid !== 1'b1) begin errors++; $display("FAIL load_pend: got pv=%b want 1", pend_valid); end
    cyc();
    checks++;
    if (pend_valid !== 1'b0) begin errors++; $display("FAIL stopped_commit: got pv=%b want 0", pend_valid); end
    start = 1'b1;
    cyc(); e = 0;
    for (int k = 1; k < SCAN_DIV; k++) begin
      cyc(); e++;
      checks++;
      if (led_en !== 4'hF || led_seg !== 7'h7F) begin
        errors++; $display("FAIL first_dark e=%0d: got en=%h seg=%h want F 7f", e, led_en, led_seg);
      end
    end
    for (int s = 0; s < 5; s++) begin
      cyc(); e++;
      checks++;
      if (led_en !== en_w[s] || led_seg !== sg_w[s] || led_dp !== dp_w[s] || frame_done !== fd_w[s]) begin
        errors++;
        $display("FAIL scan_step %0d: got en=%h seg=%h dp=%b fd=%b want en=%h seg=%h dp=%b fd=%b",
                 s, led_en, led_seg, led_dp, frame_done, en_w[s], sg_w[s], dp_w[s], fd_w[s]);
      end
      if (s < 4) repeat (SCAN_DIV - 1) begin cyc(); e++; end
    end
    cyc(); e++;
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL fd_one_cycle: got fd=%b want 0", frame_done); end
  endtask

  task automatic test_reload_midframe();
    int d;
    int wrap_e;
    while (e < SCAN_DIV + FRAME + SCAN_DIV + 1) begin cyc(); e++; end
    wrap_e = SCAN_DIV + 2 * FRAME;
    value = 16'h0000; dp_mask = 4'b0000; load = 1'b1;
    cyc(); e++;
    checks++;
    if (pend_valid !== 1'b1) begin errors++; $display("FAIL mid_load_pend: got pv=%b want 1", pend_valid); end
    while (e < wrap_e) begin
      cyc(); e++;
      d = ((e - SCAN_DIV) / SCAN_DIV) % DIGITS;
      checks++;
      if (e < wrap_e) begin
        if (led_en !== exp_en(d) || led_seg !== exp_seg(16'h12AF, d) || pend_valid !== 1'b1 || frame_done !== 1'b0) begin
          errors++;
          $display("FAIL old_frame e=%0d: got en=%h seg=%h pv=%b fd=%b want en=%h seg=%h pv=1 fd=0",
                   e, led_en, led_seg, pend_valid, frame_done, exp_en(d), exp_seg(16'h12AF, d));
        end
      end else begin
        if (led_en !== 4'hE || led_seg !== 7'h40 || led_dp !== 1'b1 || frame_done !== 1'b1 || pend_valid !== 1'b0) begin
          errors++;
          $display("FAIL wrap_commit: got en=%h seg=%h dp=%b fd=%b pv=%b want E 40 1 1 0",
                   led_en, led_seg, led_dp, frame_done, pend_valid);
        end
      end
    end
  endtask

  task automatic test_start_stop_same();
    start = 1'b1; stop = 1'b1;
    cyc();
    checks++;
    if (led_en !== 4'hF || led_seg !== 7'h7F || led_dp !== 1'b1) begin
      errors++; $display("FAIL stop_wins: got en=%h seg=%h dp=%b want F 7f 1", led_en, led_seg, led_dp);
    end
    for (int k = 0; k < 2 * FRAME; k++) begin
      cyc();
      checks++;
      if (frame_done !== 1'b0 || led_en !== 4'hF) begin
        errors++; $display("FAIL stopped_quiet k=%0d: got fd=%b en=%h want 0 F", k, frame_done, led_en);
      end
    end
    start = 1'b1;
    cyc();
    for (int k = 1; k <= SCAN_DIV; k++) begin
      cyc();
      checks++;
      if (k < SCAN_DIV) begin
        if (led_en !== 4'hF) begin errors++; $display("FAIL restart_dark k=%0d: got en=%h want F", k, led_en); end
      end else begin
        if (led_en !== 4'hE || led_seg !== 7'h40) begin
          errors++; $display("FAIL restart_digit0: got en=%h seg=%h want E 40", led_en, led_seg);
        end
      end
    end
  endtask

  task automatic test_lzb();
`ifdef SEG_SCAN_LZB_EN
    logic [6:0] w30 [4] = '{7'h40, 7'h30, 7'h7F, 7'h7F};
    logic [6:0] w00 [4] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
`else
    logic [6:0] w30 [4] = '{7'h40, 7'h30, 7'h40, 7'h40};
    logic [6:0] w00 [4] = '{7'h40, 7'h40, 7'h40, 7'h40};
`endif
    logic [15:0] pats [2] = '{16'h0030, 16'h0000};
    for (int p = 0; p < 2; p++) begin
      stop = 1'b1; cyc(); cyc();
      value = pats[p]; dp_mask = 4'b0000; load = 1'b1;
      cyc(); cyc();
      start = 1'b1; cyc();
      for (int d = 0; d < DIGITS; d++) begin
        repeat (SCAN_DIV) cyc();
        checks++;
        if (led_en !== exp_en(d) || led_seg !== (p == 0 ? w30[d] : w00[d]) || led_dp !== 1'b1) begin
          errors++;
          $display("FAIL lzb pat=%h digit=%0d: got en=%h seg=%h dp=%b want en=%h seg=%h dp=1",
                   pats[p], d, led_en, led_seg, led_dp, exp_en(d), (p == 0 ? w30[d] : w00[d]));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] shown, pend, nv;
    logic [3:0]  sdp, pdp, ndp;
    logic        pv_m, ld, wrap;
    logic [3:0]  en_x;
    logic [6:0]  seg_x;
    logic        dp_x;
    int          d;
    for (int it = 0; it < 4; it++) begin
      stop = 1'b1; cyc(); cyc();
      nv = 16'($urandom); ndp = 4'($urandom_range(0, 15));
      value = nv; dp_mask = ndp; load = 1'b1;
      cyc(); cyc();
      shown = nv; sdp = ndp; pend = nv; pdp = ndp; pv_m = 1'b0;
      start = 1'b1; cyc(); e = 0;
      for (int n = 0; n < 3 * FRAME + 7; n++) begin
        ld = ($urandom_range(0, 7) == 0);
        if (ld) begin
          nv = 16'($urandom); ndp = 4'($urandom_range(0, 15));
          value = nv; dp_mask = ndp; load = 1'b1;
        end
        if ($urandom_range(0, 15) == 0) start = 1'b1;
        cyc(); e++;
        wrap = (e > SCAN_DIV) && ((e - SCAN_DIV) % FRAME == 0);
        if (wrap && pv_m) begin shown = pend; sdp = pdp; pv_m = 1'b0; end
        if (ld) begin pend = nv; pdp = ndp; pv_m = 1'b1; end
        if (e < SCAN_DIV) begin
          en_x = 4'hF; seg_x = 7'h7F; dp_x = 1'b1;
        end else begin
          d = ((e - SCAN_DIV) / SCAN_DIV) % DIGITS;
          en_x = exp_en(d); seg_x = exp_seg(shown, d); dp_x = ~sdp[d];
        end
        checks++;
        if (led_en !== en_x || led_seg !== seg_x || led_dp !== dp_x || frame_done !== wrap || pend_valid !== pv_m) begin
          errors++;
          $display("FAIL random it=%0d e=%0d: got en=%h seg=%h dp=%b fd=%b pv=%b want en=%h seg=%h dp=%b fd=%b pv=%b",
                   it, e, led_en, led_seg, led_dp, frame_done, pend_valid, en_x, seg_x, dp_x, wrap, pv_m);
        end
      end
      stop = 1'b1; cyc();
      checks++;
      if (led_en !== 4'hF || led_seg !== 7'h7F || led_dp !== 1'b1 || frame_done !== 1'b0) begin
        errors++; $display("FAIL random_stop it=%0d: got en=%h seg=%h dp=%b fd=%b", it, led_en, led_seg, led_dp, frame_done);
      end
      cyc();
      checks++;
      if (pend_valid !== 1'b0) begin errors++; $display("FAIL stop_commit it=%0d: got pv=%b want 0", it, pend_valid); end
    end
  endtask

  task automatic test_reset_mid();
    value = 16'hBEEF; dp_mask = 4'b0101; load = 1'b1;
    cyc(); cyc();
    start = 1'b1; cyc(); e = 0;
    while (e < SCAN_DIV + 2 * SCAN_DIV) begin cyc(); e++; end
    checks++;
    if (led_en !== 4'hB || led_seg !== exp_seg(16'hBEEF, 2) || led_dp !== 1'b0) begin
      errors++; $display("FAIL pre_reset_digit2: got en=%h seg=%h dp=%b want B %h 0", led_en, led_seg, led_dp, exp_seg(16'hBEEF, 2));
    end
    value = 16'h1234; dp_mask = 4'b1111; load = 1'b1;
    cyc();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({led_en, led_seg, led_dp, frame_done, pend_valid} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: got en=%h seg=%h dp=%b fd=%b pv=%b want F 7f 1 0 0", led_en, led_seg, led_dp, frame_done, pend_valid);
    end
    cyc(); cyc();
    rst = 1'b0;
    start = 1'b1; cyc();
    for (int k = 1; k <= 2 * SCAN_DIV; k++) begin
      cyc();
      checks++;
      if (k < SCAN_DIV) begin
        if (led_en !== 4'hF) begin errors++; $display("FAIL post_reset_dark k=%0d: got en=%h want F", k, led_en); end
      end else begin
        if (led_en !== exp_en(k / SCAN_DIV - 1) || led_seg !== exp_seg(16'h0000, k / SCAN_DIV - 1) || led_dp !== 1'b1) begin
          errors++;
          $display("FAIL post_reset_shadow k=%0d: got en=%h seg=%h dp=%b want en=%h seg=%h dp=1",
                   k, led_en, led_seg, led_dp, exp_en(k / SCAN_DIV - 1), exp_seg(16'h0000, k / SCAN_DIV - 1));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reload_midframe();
    test_start_stop_same();
    test_lzb();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
